// File: rtl/crc_cdc_pkg.sv
// ============================================================================
// Package     : crc_cdc_pkg
// Description : Constants and types shared by the clk1<->clk_2 CRC CDC path:
//               result word width, CRC field widths, the result transmitter
//               FSM encoding and a saturating counter helper.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package crc_cdc_pkg;

  // Result word carried back to the clk1 domain (codeword or check verdict).
  localparam int CRC_DATA_W = 60;

  // CRC field widths, shared with the clk_2 CRC engine.
  localparam int CRC5_W = 5;
  localparam int CRC8_W = 8;

  // Result transmitter FSM encoding.
  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_LOAD     = 2'd1;
  localparam logic [1:0] ST_WAIT_ACK = 2'd2;

  typedef enum logic [1:0] {
    IDLE     = ST_IDLE,
    LOAD     = ST_LOAD,
    WAIT_ACK = ST_WAIT_ACK
  } tx_state_t;

  // 16-bit increment that sticks at all-ones.
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/result_fifo.sv
// ============================================================================
// Module      : result_fifo
// Description : Synchronous DEPTH x DATA_W FIFO with read/write pointers and
//               an occupancy counter. Head is the oldest word (combinational
//               read of the storage). A push while full is accepted only when
//               a pop happens on the same edge. There is no write-through: a
//               word written at one edge is visible at head only afterwards.
// Ports       : clk, rst_n (async, active-low)
//               push/din   - write request and data
//               pop        - read request (ignored while empty)
//               head       - oldest stored word
//               empty      - no words stored
//               ready      - registered "count < DEPTH"
//               push_ok    - the current push request is accepted
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module result_fifo
  import crc_cdc_pkg::*;
#(
  parameter int DATA_W = CRC_DATA_W,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic [DATA_W-1:0] din,
  input  logic              pop,
  output logic [DATA_W-1:0] head,
  output logic              empty,
  output logic              ready,
  output logic              push_ok
);

  localparam int                 c_ptr_w = $clog2(DEPTH);
  localparam int                 c_cnt_w = c_ptr_w + 1;
  localparam logic [c_cnt_w-1:0] c_depth = c_cnt_w'(DEPTH);

  logic [DATA_W-1:0]  r_mem [DEPTH];
  logic [c_ptr_w-1:0] r_wr_ptr;
  logic [c_ptr_w-1:0] r_rd_ptr;
  logic [c_cnt_w-1:0] r_count;
  logic [c_cnt_w-1:0] w_count_nxt;
  logic               r_ready;
  logic               w_pop_ok;

  assign w_pop_ok = pop && (r_count != '0);
  // When full, the slot freed by a same-edge pop is the one being written.
  assign push_ok  = push && (r_ready || w_pop_ok);

  always_comb begin
    w_count_nxt = r_count;
    case ({push_ok, w_pop_ok})
      2'b10:   w_count_nxt = r_count + c_cnt_w'(1);
      2'b01:   w_count_nxt = r_count - c_cnt_w'(1);
      default: w_count_nxt = r_count;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_ready  <= 1'b1;
    end else begin
      if (push_ok) begin
        r_wr_ptr <= r_wr_ptr + c_ptr_w'(1);
      end
      if (w_pop_ok) begin
        r_rd_ptr <= r_rd_ptr + c_ptr_w'(1);
      end
      r_count <= w_count_nxt;
      r_ready <= (w_count_nxt != c_depth);
    end
  end

  // Storage carries no reset; validity is tracked by the pointers and count.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      r_mem[r_wr_ptr] <= din;
    end
  end

  assign head  = r_mem[r_rd_ptr];
  assign empty = (r_count == '0);
  assign ready = r_ready;

endmodule

`default_nettype wire

// File: rtl/clk2_result_tx.sv
// ============================================================================
// Module      : clk2_result_tx
// Description : clk_2-side result transmitter, the send half of a toggle-flag
//               CDC handshake. Result words from the CRC engine are queued in
//               a small FIFO and handed to clk1 one at a time as held data
//               plus a toggled request flag; the next word waits until the
//               clk1 side echoes the toggle back on clk1_ack.
// Ports       : clk_2, rst_n (async, active-low)
//               res_valid/res_data - result word pulse from the engine
//               res_ready          - FIFO not full (registered)
//               clk1_ack           - ack toggle level from clk1 (asynchronous)
//               clk2_tx_data       - word presented to clk1, held while pending
//               clk2_tx_flag       - request toggle, one toggle per word
//               busy               - word in flight or queued
//               overflow           - sticky, a result word was dropped
//               tx_count, drop_count (CRC_TX_STATS_EN only) - saturating
//               counts of words sent and words dropped
// Config      : `define CRC_TX_STATS_EN to add the statistics counters.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module clk2_result_tx
  import crc_cdc_pkg::*;
#(
  parameter int DATA_W      = CRC_DATA_W,
  parameter int DEPTH       = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk_2,
  input  logic              rst_n,
  input  logic              res_valid,
  input  logic [DATA_W-1:0] res_data,
  output logic              res_ready,
  input  logic              clk1_ack,
  output logic [DATA_W-1:0] clk2_tx_data,
  output logic              clk2_tx_flag,
  output logic              busy,
  output logic              overflow
`ifdef CRC_TX_STATS_EN
  ,
  output logic [15:0]       tx_count,
  output logic [15:0]       drop_count
`endif
);

  tx_state_t               r_state;
  logic [SYNC_STAGES-1:0]  r_ack_sync;
  logic                    r_ack_prev;
  logic                    w_ack_edge;
  logic                    w_pop;
  logic                    w_push_ok;
  logic                    w_empty;
  logic [DATA_W-1:0]       w_head;

  // --------------------------------------------------------------------------
  // Result queue
  // --------------------------------------------------------------------------
  result_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk     (clk_2),
    .rst_n   (rst_n),
    .push    (res_valid),
    .din     (res_data),
    .pop     (w_pop),
    .head    (w_head),
    .empty   (w_empty),
    .ready   (res_ready),
    .push_ok (w_push_ok)
  );

  // --------------------------------------------------------------------------
  // Ack toggle synchronizer and edge detector. ack_edge is a one-cycle pulse
  // for every toggle of clk1_ack, delayed by the synchronizer depth.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_2 or negedge rst_n) begin
    if (!rst_n) begin
      r_ack_sync <= '0;
      r_ack_prev <= 1'b0;
    end else begin
      r_ack_sync <= {r_ack_sync[SYNC_STAGES-2:0], clk1_ack};
      r_ack_prev <= r_ack_sync[SYNC_STAGES-1];
    end
  end

  assign w_ack_edge = r_ack_sync[SYNC_STAGES-1] ^ r_ack_prev;

  // --------------------------------------------------------------------------
  // Transmit FSM. Data is loaded one full cycle before the flag toggles so
  // the clk1 side never samples data that is still settling.
  // --------------------------------------------------------------------------
  assign w_pop = (r_state == IDLE) && !w_empty;

  always_ff @(posedge clk_2 or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      clk2_tx_data <= '0;
      clk2_tx_flag <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (!w_empty) begin
            clk2_tx_data <= w_head;
            r_state      <= LOAD;
          end
        end
        LOAD: begin
          clk2_tx_flag <= ~clk2_tx_flag;
          r_state      <= WAIT_ACK;
        end
        WAIT_ACK: begin
          // Ack edges seen in IDLE or LOAD are stale/spurious and ignored.
          if (w_ack_edge) begin
            r_state <= IDLE;
          end
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign busy = (r_state != IDLE) || !w_empty;

  // --------------------------------------------------------------------------
  // Sticky overflow flag
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_2 or negedge rst_n) begin
    if (!rst_n) begin
      overflow <= 1'b0;
    end else if (res_valid && !w_push_ok) begin
      overflow <= 1'b1;
    end
  end

`ifdef CRC_TX_STATS_EN
  // --------------------------------------------------------------------------
  // Saturating statistics counters
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_2 or negedge rst_n) begin
    if (!rst_n) begin
      tx_count   <= 16'd0;
      drop_count <= 16'd0;
    end else begin
      if (r_state == LOAD) begin
        tx_count <= sat_inc16(tx_count);
      end
      if (res_valid && !w_push_ok) begin
        drop_count <= sat_inc16(drop_count);
      end
    end
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_clk2_result_tx.sv
// ============================================================================
// Module      : tb_clk2_result_tx
// Description : Self-checking bench for clk2_result_tx. A behavioural clk1
//               responder watches the request flag, records each delivered
//               word and echoes the toggle on clk1_ack after a delay.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_clk2_result_tx;

  localparam int DATA_W = 60;
  localparam int DEPTH  = 4;

  logic              clk_2 = 1'b0;
  logic              rst_n = 1'b0;
  logic              res_valid = 1'b0;
  logic [DATA_W-1:0] res_data = '0;
  logic              res_ready;
  logic              clk1_ack;
  logic [DATA_W-1:0] clk2_tx_data;
  logic              clk2_tx_flag;
  logic              busy;
  logic              overflow;
`ifdef CRC_TX_STATS_EN
  logic [15:0]       tx_count;
  logic [15:0]       drop_count;
`endif

  int checks   = 0;
  int failures = 0;

  clk2_result_tx #(
    .DATA_W      (DATA_W),
    .DEPTH       (DEPTH),
    .SYNC_STAGES (2)
  ) dut (
    .clk_2        (clk_2),
    .rst_n        (rst_n),
    .res_valid    (res_valid),
    .res_data     (res_data),
    .res_ready    (res_ready),
    .clk1_ack     (clk1_ack),
    .clk2_tx_data (clk2_tx_data),
    .clk2_tx_flag (clk2_tx_flag),
    .busy         (busy),
    .overflow     (overflow)
`ifdef CRC_TX_STATS_EN
    ,
    .tx_count     (tx_count),
    .drop_count   (drop_count)
`endif
  );

  always #5 clk_2 = ~clk_2;

  // --------------------------------------------------------------------------
  // clk1-side responder model
  // --------------------------------------------------------------------------
  logic [DATA_W-1:0] recv_q[$];
  logic        mon_flag;
  logic        pend;
  int          pend_cnt;
  int          ack_delay = 4;
  bit          ack_en    = 1'b1;
  bit          ack_rand  = 1'b0;
  int unsigned spur_req  = 0;
  int unsigned spur_done = 0;

  always @(negedge clk_2) begin
    if (!rst_n) begin
      mon_flag  = 1'b0;
      pend      = 1'b0;
      pend_cnt  = 0;
      clk1_ack  = 1'b0;
      spur_done = spur_req;
    end else begin
      if (spur_req != spur_done) begin
        clk1_ack  = ~clk1_ack;
        spur_done = spur_req;
      end
      if (clk2_tx_flag !== mon_flag) begin
        mon_flag = clk2_tx_flag;
        recv_q.push_back(clk2_tx_data);
        pend     = 1'b1;
        pend_cnt = ack_rand ? int'($urandom_range(1, 8)) : ack_delay;
      end else if (pend && ack_en) begin
        if (pend_cnt <= 1) begin
          clk1_ack = ~clk1_ack;
          pend     = 1'b0;
        end else begin
          pend_cnt--;
        end
      end
    end
  end

  // One step: just past the falling edge, after the responder has acted.
  task automatic step();
    @(negedge clk_2);
    #1;
  endtask

  task automatic pulse(input logic [DATA_W-1:0] d);
    res_valid = 1'b1;
    res_data  = d;
    step();
    res_valid = 1'b0;
  endtask

  // Wait until the responder has recorded `target` words; returns 0 on timeout.
  task automatic wait_recv(input int target, input int limit, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < limit; i++) begin
      if (recv_q.size() >= target) begin
        ok = 1'b1;
        break;
      end
      step();
    end
  endtask

  task automatic wait_idle(input int limit, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < limit; i++) begin
      if (busy === 1'b0 && !pend) begin
        ok = 1'b1;
        break;
      end
      step();
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    step();
  endtask

  // --------------------------------------------------------------------------
  task automatic test_reset();
    rst_n = 1'b0;
    step();
    checks++;
    if ({clk2_tx_data, clk2_tx_flag, busy, overflow, res_ready} !== {{DATA_W{1'b0}}, 4'b0001}) begin
      failures++;
      $display("FAIL reset_outputs: data=%h flag=%b busy=%b ovf=%b ready=%b, required 0/0/0/0/1",
               clk2_tx_data, clk2_tx_flag, busy, overflow, res_ready);
    end
`ifdef CRC_TX_STATS_EN
    checks++;
    if (tx_count !== 16'd0 || drop_count !== 16'd0) begin
      failures++;
      $display("FAIL reset_stats: tx=%0d drop=%0d, required 0/0", tx_count, drop_count);
    end
`endif
    step();
    rst_n = 1'b1;
    step();
  endtask

  // --------------------------------------------------------------------------
  task automatic test_single();
    logic [DATA_W-1:0] v;
    logic              ack0;
    bit                ok;
    int                base;
    v         = 60'h0123456789ABCDE;
    ack_delay = 4;
    base      = recv_q.size();
    pulse(v);                         // E0 passed
    checks++;
    if (clk2_tx_data !== '0 || busy !== 1'b1) begin
      failures++;
      $display("FAIL single_e0: data=%h busy=%b, required 0 and 1", clk2_tx_data, busy);
    end
    step();                           // E1 passed
    checks++;
    if (clk2_tx_data !== v || clk2_tx_flag !== 1'b0) begin
      failures++;
      $display("FAIL single_e1: data=%h flag=%b, required %h and 0", clk2_tx_data, clk2_tx_flag, v);
    end
    step();                           // E2 passed
    checks++;
    if (clk2_tx_flag !== 1'b1) begin
      failures++;
      $display("FAIL single_e2_flag: flag=%b, required 1", clk2_tx_flag);
    end
    ack0 = clk1_ack;
    ok   = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (clk1_ack !== ack0) begin
        ok = 1'b1;
        break;
      end
    end
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL single_ack_timeout: ack=%b, required a toggle", clk1_ack);
    end
    step();
    step();
    checks++;
    if (busy !== 1'b1) begin
      failures++;
      $display("FAIL single_busy_hold: busy=%b, required 1", busy);
    end
    step();
    checks++;
    if (busy !== 1'b0 || clk2_tx_data !== v) begin
      failures++;
      $display("FAIL single_busy_clear: busy=%b data=%h, required 0 and %h", busy, clk2_tx_data, v);
    end
    checks++;
    if (recv_q.size() != base + 1 || recv_q[base] !== v) begin
      failures++;
      $display("FAIL single_recv: count=%0d, required %0d", recv_q.size() - base, 1);
    end
  endtask

  // --------------------------------------------------------------------------
  task automatic test_burst();
    bit ok;
    int base;
    logic [DATA_W-1:0] exp_q[$];
    ack_delay = 10;
    base      = recv_q.size();
    for (int k = 1; k <= 4; k++) begin
      exp_q.push_back(DATA_W'(k));
      pulse(DATA_W'(k));
    end
    wait_recv(base + 4, 300, ok);
    wait_idle(100, ok);
    checks++;
    if (!ok || recv_q.size() != base + 4) begin
      failures++;
      $display("FAIL burst_count: words=%0d, required 4", recv_q.size() - base);
    end
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (base + k >= recv_q.size() || recv_q[base + k] !== exp_q[k]) begin
        failures++;
        $display("FAIL burst_order[%0d]: word=%h, required %h", k,
                 (base + k < recv_q.size()) ? recv_q[base + k] : '0, exp_q[k]);
      end
    end
    checks++;
    if (overflow !== 1'b0) begin
      failures++;
      $display("FAIL burst_overflow: overflow=%b, required 0", overflow);
    end
    ack_delay = 4;
  endtask

  // --------------------------------------------------------------------------
  task automatic test_overflow();
    bit ok;
    int base;
    int occ;
    int n_acc;
    int n_pulse;
    n_pulse = 6;
    n_acc   = (n_pulse < DEPTH + 1) ? n_pulse : DEPTH + 1;  // tx reg + FIFO
    do_reset();
    base   = recv_q.size();
    ack_en = 1'b0;
    for (int k = 1; k <= n_pulse; k++) begin
      pulse(DATA_W'(k));
      // First word leaves the FIFO on the edge the second arrives.
      occ = (k == 1) ? 1 : ((k - 1 < DEPTH) ? k - 1 : DEPTH);
      checks++;
      if (res_ready !== (occ < DEPTH)) begin
        failures++;
        $display("FAIL ovf_ready[%0d]: ready=%b, required %b", k, res_ready, occ < DEPTH);
      end
    end
    checks++;
    if (overflow !== 1'b1) begin
      failures++;
      $display("FAIL ovf_flag: overflow=%b, required 1", overflow);
    end
    for (int i = 0; i < 10; i++) step();
    checks++;
    if (recv_q.size() != base + 1) begin
      failures++;
      $display("FAIL ovf_blocked: words=%0d, required 1", recv_q.size() - base);
    end
    ack_delay = 3;
    ack_en    = 1'b1;
    wait_recv(base + n_acc, 400, ok);
    wait_idle(100, ok);
    for (int i = 0; i < 10; i++) step();
    checks++;
    if (!ok || recv_q.size() != base + n_acc) begin
      failures++;
      $display("FAIL ovf_count: words=%0d, required %0d", recv_q.size() - base, n_acc);
    end
    for (int k = 0; k < n_acc; k++) begin
      checks++;
      if (base + k >= recv_q.size() || recv_q[base + k] !== DATA_W'(k + 1)) begin
        failures++;
        $display("FAIL ovf_order[%0d]: word=%h, required %h", k,
                 (base + k < recv_q.size()) ? recv_q[base + k] : '0, DATA_W'(k + 1));
      end
    end
    checks++;
    if (overflow !== 1'b1 || res_ready !== 1'b1) begin
      failures++;
      $display("FAIL ovf_sticky: overflow=%b ready=%b, required 1 and 1", overflow, res_ready);
    end
`ifdef CRC_TX_STATS_EN
    checks++;
    if (tx_count !== 16'(n_acc) || drop_count !== 16'(n_pulse - n_acc)) begin
      failures++;
      $display("FAIL ovf_stats: tx=%0d drop=%0d, required %0d/%0d",
               tx_count, drop_count, n_acc, n_pulse - n_acc);
    end
`endif
    ack_delay = 4;
  endtask

  // --------------------------------------------------------------------------
  task automatic test_spurious();
    logic [DATA_W-1:0] d0;
    logic [DATA_W-1:0] v;
    logic              f0;
    int                base;
    bit                ok;
    d0   = clk2_tx_data;
    f0   = clk2_tx_flag;
    base = recv_q.size();
    spur_req++;
    for (int i = 0; i < 6; i++) step();
    checks++;
    if (clk2_tx_flag !== f0 || clk2_tx_data !== d0 || busy !== 1'b0 || recv_q.size() != base) begin
      failures++;
      $display("FAIL spur_quiet: flag=%b data=%h busy=%b, required %b %h 0",
               clk2_tx_flag, clk2_tx_data, busy, f0, d0);
    end
    // Still in IDLE: a new word must load with the normal one-edge latency.
    v = 60'hABCDEF012345678;
    pulse(v);
    step();
    checks++;
    if (clk2_tx_data !== v || clk2_tx_flag !== f0) begin
      failures++;
      $display("FAIL spur_idle_latency: data=%h flag=%b, required %h %b", clk2_tx_data, clk2_tx_flag, v, f0);
    end
    wait_recv(base + 1, 50, ok);
    wait_idle(100, ok);
    checks++;
    if (!ok || recv_q.size() != base + 1 || recv_q[base] !== v) begin
      failures++;
      $display("FAIL spur_deliver: words=%0d, required 1", recv_q.size() - base);
    end
  endtask

  // --------------------------------------------------------------------------
  task automatic test_reset_mid();
    logic [DATA_W-1:0] v;
    bit                ok;
    int                base;
    base   = recv_q.size();
    ack_en = 1'b0;
    pulse(60'h111);
    pulse(60'h222);
    pulse(60'h333);
    wait_recv(base + 1, 20, ok);
    step();
    step();
    rst_n = 1'b0;
    #1;
    checks++;
    if ({clk2_tx_data, clk2_tx_flag, busy, overflow, res_ready} !== {{DATA_W{1'b0}}, 4'b0001}) begin
      failures++;
      $display("FAIL rstmid_outputs: data=%h flag=%b busy=%b ovf=%b ready=%b, required 0/0/0/0/1",
               clk2_tx_data, clk2_tx_flag, busy, overflow, res_ready);
    end
    step();
    rst_n  = 1'b1;
    ack_en = 1'b1;
    step();
    base = recv_q.size();
    v    = 60'h0FEDCBA98765432;
    pulse(v);
    wait_recv(base + 1, 50, ok);
    wait_idle(100, ok);
    for (int i = 0; i < 10; i++) step();
    checks++;
    if (!ok || recv_q.size() != base + 1 || recv_q[base] !== v || clk2_tx_flag !== 1'b1) begin
      failures++;
      $display("FAIL rstmid_post: words=%0d flag=%b, required 1 word and flag 1",
               recv_q.size() - base, clk2_tx_flag);
    end
  endtask

  // --------------------------------------------------------------------------
  task automatic test_random();
    logic [DATA_W-1:0] exp_q[$];
    logic [63:0]       r64;
    int                base;
    int                sent;
    int                gap;
    bit                ok;
    base     = recv_q.size();
    sent     = 0;
    ack_rand = 1'b1;
    while (sent < 40) begin
      // Keep at most DEPTH-1 words unreceived so the FIFO never fills.
      ok = 1'b0;
      for (int i = 0; i < 200; i++) begin
        if (sent - (recv_q.size() - base) < DEPTH) begin
          ok = 1'b1;
          break;
        end
        step();
      end
      if (!ok) begin
        checks++;
        failures++;
        $display("FAIL rand_stall: sent=%0d recv=%0d, required progress", sent, recv_q.size() - base);
        break;
      end
      checks++;
      if (res_ready !== 1'b1) begin
        failures++;
        $display("FAIL rand_ready[%0d]: ready=%b, required 1", sent, res_ready);
      end
      r64 = {$urandom, $urandom};
      exp_q.push_back(r64[DATA_W-1:0]);
      pulse(r64[DATA_W-1:0]);
      sent++;
      gap = int'($urandom_range(0, 3));
      for (int i = 0; i < gap; i++) step();
    end
    wait_recv(base + sent, 600, ok);
    wait_idle(100, ok);
    checks++;
    if (!ok || recv_q.size() != base + exp_q.size()) begin
      failures++;
      $display("FAIL rand_count: words=%0d, required %0d", recv_q.size() - base, exp_q.size());
    end
    for (int k = 0; k < exp_q.size(); k++) begin
      checks++;
      if (base + k >= recv_q.size() || recv_q[base + k] !== exp_q[k]) begin
        failures++;
        $display("FAIL rand_order[%0d]: word=%h, required %h", k,
                 (base + k < recv_q.size()) ? recv_q[base + k] : '0, exp_q[k]);
      end
    end
    checks++;
    if (overflow !== 1'b0) begin
      failures++;
      $display("FAIL rand_overflow: overflow=%b, required 0", overflow);
    end
    ack_rand = 1'b0;
  endtask

  // --------------------------------------------------------------------------
  initial begin
    test_reset();
    test_single();
    test_burst();
    test_overflow();
    test_spurious();
    test_reset_mid();
    do_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
